// File: rtl/clint.sv
// clint: core-local interruptor exposing msip, mtimecmp and mtime on a single-beat valid/ready bus.
// Build option: define CLINT_PRESCALER_EN to advance mtime once every RTC_DIV clocks instead of every clock.
module clint #(
    parameter int unsigned RTC_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    // Word offsets (byte offset >> 2) within the 64 KiB CLINT window.
    localparam logic [13:0] AddrMsip    = 14'h0000;
    localparam logic [13:0] AddrCmpLo   = 14'h1000;
    localparam logic [13:0] AddrCmpHi   = 14'h1001;
    localparam logic [13:0] AddrMtimeLo = 14'h2FFE;
    localparam logic [13:0] AddrMtimeHi = 14'h2FFF;

    logic        msip_q, msip_d;
    logic [63:0] cmp_q, cmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic        mtip_q, mtip_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic [13:0] word_addr;
    logic        wr_en;
    logic        rd_en;
    logic        tick;
    logic [63:0] mtime_inc;
    logic [31:0] rd_word;

    logic unused_ok;
    assign unused_ok = ^{clint_instr, clint_addr[31:16], clint_addr[1:0]};

    assign word_addr = clint_addr[15:2];
    assign wr_en     = clint_valid && (clint_wstrb != 4'b0000);
    assign rd_en     = clint_valid && (clint_wstrb == 4'b0000);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] DivLast = 16'(RTC_DIV - 1);

    logic [15:0] presc_q, presc_d;

    assign tick = (presc_q == DivLast);

    always_comb begin
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic [15:0] unused_rtc_div;
    assign unused_rtc_div = 16'(RTC_DIV);
    assign tick           = 1'b1;
`endif

    always_comb begin
        mtime_inc = mtime_q + 64'(tick);
        msip_d    = msip_q;
        cmp_d     = cmp_q;
        // Written bytes win over the tick; the rest carry the incremented value.
        mtime_d   = mtime_inc;
        if (wr_en) begin
            case (word_addr)
                AddrMsip: begin
                    if (clint_wstrb[0]) begin
                        msip_d = clint_wdata[0];
                    end
                end
                AddrCmpLo:   cmp_d[31:0]    = merge_bytes(cmp_q[31:0], clint_wdata, clint_wstrb);
                AddrCmpHi:   cmp_d[63:32]   = merge_bytes(cmp_q[63:32], clint_wdata, clint_wstrb);
                AddrMtimeLo: mtime_d[31:0]  = merge_bytes(mtime_inc[31:0], clint_wdata, clint_wstrb);
                AddrMtimeHi: mtime_d[63:32] = merge_bytes(mtime_inc[63:32], clint_wdata, clint_wstrb);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = 32'd0;
        case (word_addr)
            AddrMsip:    rd_word = {31'd0, msip_q};
            AddrCmpLo:   rd_word = cmp_q[31:0];
            AddrCmpHi:   rd_word = cmp_q[63:32];
            AddrMtimeLo: rd_word = mtime_q[31:0];
            AddrMtimeHi: rd_word = mtime_q[63:32];
            default:     rd_word = 32'd0;
        endcase
        rdata_d = rd_en ? rd_word : 32'd0;
        ready_d = clint_valid;
        mtip_d  = (mtime_q >= cmp_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            msip_q  <= 1'b0;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q <= 64'd0;
            mtip_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            msip_q  <= msip_d;
            cmp_q   <= cmp_d;
            mtime_q <= mtime_d;
            mtip_q  <= mtip_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign clint_rdata = rdata_q;
    assign clint_ready = ready_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_clint;

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned P = 4;
`else
    localparam int unsigned P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    clint #(.RTC_DIV(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .clint_valid (valid),
        .clint_instr (instr),
        .clint_addr  (addr),
        .clint_wdata (wdata),
        .clint_wstrb (wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural registers updated once per rising edge.
    logic [63:0] m_mtime, m_cmp, mdl_next;
    logic        m_msip, m_mtip, m_ready;
    logic [31:0] m_rdata, mdl_rd;
    logic [15:0] mdl_off;
    int unsigned m_phase;
    bit          mdl_tick;

    always @(posedge clk) begin
        if (!rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_mtip = 1'b0;
            m_ready = 1'b0; m_rdata = 32'd0; m_phase = 0;
        end else begin
            mdl_tick = (m_phase == P - 1);
            m_phase  = mdl_tick ? 0 : m_phase + 1;
            mdl_off  = addr[15:0] & 16'hFFFC;
            if (mdl_off == 16'h0000)      mdl_rd = {31'd0, m_msip};
            else if (mdl_off == 16'h4000) mdl_rd = m_cmp[31:0];
            else if (mdl_off == 16'h4004) mdl_rd = m_cmp[63:32];
            else if (mdl_off == 16'hBFF8) mdl_rd = m_mtime[31:0];
            else if (mdl_off == 16'hBFFC) mdl_rd = m_mtime[63:32];
            else                          mdl_rd = 32'd0;
            m_mtip   = (m_mtime >= m_cmp);
            mdl_next = m_mtime + (mdl_tick ? 64'd1 : 64'd0);
            if (valid && wstrb != 4'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        case (mdl_off)
                            16'h0000: if (b == 0) m_msip = wdata[0];
                            16'h4000: m_cmp[8*b +: 8] = wdata[8*b +: 8];
                            16'h4004: m_cmp[32+8*b +: 8] = wdata[8*b +: 8];
                            16'hBFF8: mdl_next[8*b +: 8] = wdata[8*b +: 8];
                            16'hBFFC: mdl_next[32+8*b +: 8] = wdata[8*b +: 8];
                            default: ;
                        endcase
                    end
                end
            end
            m_mtime = mdl_next;
            m_ready = valid;
            m_rdata = (valid && wstrb == 4'd0) ? mdl_rd : 32'd0;
        end
    end

    // One-cycle request issued at a falling edge; returns at the falling edge after acceptance.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (clint_mtime !== 64'd0) begin failures++; $display("FAIL reset_mtime got=%h exp=0", clint_mtime); end
        checks++; if (clint_mtip !== 1'b0) begin failures++; $display("FAIL reset_mtip got=%b exp=0", clint_mtip); end
        checks++; if (clint_msip !== 1'b0) begin failures++; $display("FAIL reset_msip got=%b exp=0", clint_msip); end
        checks++; if (clint_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", clint_ready); end
        checks++; if (clint_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", clint_rdata); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (clint_mtime !== 64'(4 / P)) begin failures++; $display("FAIL tick_4 got=%0d exp=%0d", clint_mtime, 4 / P); end
        repeat (4) @(negedge clk);
        checks++; if (clint_mtime !== 64'(8 / P)) begin failures++; $display("FAIL tick_8 got=%0d exp=%0d", clint_mtime, 8 / P); end
        checks++; if (clint_mtime !== m_mtime) begin failures++; $display("FAIL tick_model got=%h exp=%h", clint_mtime, m_mtime); end
    endtask

    task automatic test_mtip();
        bus(32'hBFFC, 32'd0, 4'hF);
        bus(32'hBFF8, 32'd0, 4'hF);
        bus(32'h4004, 32'd0, 4'hF);
        bus(32'h4000, 32'd10, 4'hF);
        for (int i = 0; i < 200 && clint_mtime !== 64'd10; i++) @(negedge clk);
        checks++; if (clint_mtime !== 64'd10) begin failures++; $display("FAIL mtip_wait got=%0d exp=10", clint_mtime); end
        checks++; if (clint_mtip !== 1'b0) begin failures++; $display("FAIL mtip_lag got=%b exp=0", clint_mtip); end
        @(negedge clk);
        checks++; if (clint_mtip !== 1'b1) begin failures++; $display("FAIL mtip_rise got=%b exp=1", clint_mtip); end
        bus(32'h4004, 32'hFFFF_FFFF, 4'hF);
        checks++; if (clint_mtip !== 1'b1) begin failures++; $display("FAIL mtip_hold got=%b exp=1", clint_mtip); end
        @(negedge clk);
        checks++; if (clint_mtip !== 1'b0) begin failures++; $display("FAIL mtip_fall got=%b exp=0", clint_mtip); end
    endtask

    task automatic test_msip();
        bus(32'h0000, 32'hFFFF_FFFF, 4'hF);
        checks++; if (clint_msip !== 1'b1) begin failures++; $display("FAIL msip_set got=%b exp=1", clint_msip); end
        bus(32'h0000, 32'd0, 4'h0);
        checks++; if (clint_ready !== 1'b1) begin failures++; $display("FAIL msip_rd_ready got=%b exp=1", clint_ready); end
        checks++; if (clint_rdata !== 32'h1) begin failures++; $display("FAIL msip_rd got=%h exp=00000001", clint_rdata); end
        bus(32'h0000, 32'd0, 4'hF);
        checks++; if (clint_msip !== 1'b0) begin failures++; $display("FAIL msip_clr got=%b exp=0", clint_msip); end
    endtask

    task automatic test_wrap();
        bus(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        bus(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        checks++; if (clint_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffffffffffffffff", clint_mtime); end
        for (int i = 0; i < 16 && clint_mtime === 64'hFFFF_FFFF_FFFF_FFFF; i++) @(negedge clk);
        checks++; if (clint_mtime !== 64'd0) begin failures++; $display("FAIL wrap_zero got=%h exp=0", clint_mtime); end
    endtask

    task automatic test_tick_write();
        if (P > 1) begin
            for (int i = 0; i < 16 && m_phase != P - 2; i++) @(negedge clk);
        end
        bus(32'hBFF8, 32'h1122_33FF, 4'hF);
        bus(32'hBFF8, 32'h0000_AB00, 4'b0010);
        checks++; if (clint_mtime[31:0] !== 32'h1122_AB00) begin failures++; $display("FAIL tick_write got=%h exp=1122ab00", clint_mtime[31:0]); end
        checks++; if (clint_mtime !== m_mtime) begin failures++; $display("FAIL tick_write_model got=%h exp=%h", clint_mtime, m_mtime); end
    endtask

    task automatic test_back_to_back();
        bus(32'h1234, 32'd0, 4'h0);
        checks++; if (clint_ready !== 1'b1) begin failures++; $display("FAIL unmapped_ready got=%b exp=1", clint_ready); end
        checks++; if (clint_rdata !== 32'd0) begin failures++; $display("FAIL unmapped_rdata got=%h exp=0", clint_rdata); end
        valid = 1'b1; addr = 32'h4000; wstrb = 4'h0;
        @(negedge clk);
        addr = 32'h4004;
        checks++; if (clint_ready !== 1'b1 || clint_rdata !== 32'd10) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/0000000a", clint_ready, clint_rdata); end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (clint_ready !== 1'b1 || clint_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/ffffffff", clint_ready, clint_rdata); end
        @(negedge clk);
        checks++; if (clint_ready !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", clint_ready); end
        valid = 1'b1; addr = 32'h0000; rst = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        checks++; if (clint_ready !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b exp=0", clint_ready); end
        @(negedge clk);
        checks++; if (clint_ready !== 1'b0) begin failures++; $display("FAIL rst_drop_late got=%b exp=0", clint_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (clint_mtime !== m_mtime) begin failures++; $display("FAIL rst_mtime got=%h exp=%h", clint_mtime, m_mtime); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [15:0] base;
        for (int i = 0; i < 400; i++) begin
            checks++; if (clint_ready !== m_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, clint_ready, m_ready); end
            checks++; if (clint_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", i, clint_rdata, m_rdata); end
            checks++; if (clint_msip !== m_msip) begin failures++; $display("FAIL rnd_msip[%0d] got=%b exp=%b", i, clint_msip, m_msip); end
            checks++; if (clint_mtip !== m_mtip) begin failures++; $display("FAIL rnd_mtip[%0d] got=%b exp=%b", i, clint_mtip, m_mtip); end
            checks++; if (clint_mtime !== m_mtime) begin failures++; $display("FAIL rnd_mtime[%0d] got=%h exp=%h", i, clint_mtime, m_mtime); end
            r = $urandom();
            case ($urandom_range(0, 5))
                0: base = 16'h0000;
                1: base = 16'h4000;
                2: base = 16'h4004;
                3: base = 16'hBFF8;
                4: base = 16'hBFFC;
                default: base = 16'($urandom_range(0, 65535));
            endcase
            valid = ($urandom_range(0, 2) != 0);
            addr  = {r[31:16], base[15:2], r[1:0]};
            wdata = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 64));
            wstrb = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15));
            @(negedge clk);
        end
        valid = 1'b0; wstrb = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "tb_clint watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_mtip();
        test_msip();
        test_wrap();
        test_tick_write();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter RTC_DIV, default 100: clk cycles per mtime tick when prescaler compiled in; legal range 1..65535.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port clint_valid  in  1  request strobe, one-cycle pulse per request.
REQ-005 SHALL have port clint_instr  in  1  fetch flag; ignored.
REQ-006 SHALL have port clint_addr  in  32  byte address; only [15:2] decoded.
REQ-007 SHALL have port clint_wdata  in  32  write data.
REQ-008 SHALL have port clint_wstrb  in  4  byte enables; 0 = read, nonzero = write.
REQ-009 SHALL have port clint_rdata  out  32  read data, valid while clint_ready=1, else 0.
REQ-010 SHALL have port clint_ready  out  1  response strobe, one-cycle pulse.
REQ-011 SHALL have port clint_msip  out  1  machine software interrupt to CSR unit.
REQ-012 SHALL have port clint_mtip  out  1  machine timer interrupt to CSR unit.
REQ-013 SHALL have port clint_mtime  out  64  current mtime to CSR unit.

Function
REQ-014 SHALL decode offsets: 0x0000 msip, 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32].
REQ-015 SHALL accept a request in any cycle clint_valid=1, including the cycle clint_ready=1; exactly one outstanding.
REQ-016 SHALL assert clint_ready exactly one cycle after acceptance, for one cycle.
REQ-017 SHALL capture read data from register values in the acceptance cycle (pre-update).
REQ-018 SHALL apply writes per byte lane under clint_wstrb at the acceptance edge.
REQ-019 SHALL implement msip as bit 0 only; bits 31:1 read 0, writes ignored.
REQ-020 SHALL return 0 for unmapped reads, ignore unmapped writes, and still assert clint_ready.
REQ-021 SHALL hold a prescaler counting 0..RTC_DIV-1; on RTC_DIV-1 it wraps to 0 and mtime increments by 1.
REQ-022 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-023 SHALL give a software write to mtime priority over a same-cycle tick on the written bytes; unwritten bytes take the incremented value; prescaler unaffected.
REQ-024 SHALL register clint_mtip <= (mtime >= mtimecmp), unsigned 64-bit, from current register values every cycle (one-cycle lag after any update).
REQ-025 SHALL drive clint_msip directly from msip bit 0 and clint_mtime directly from the mtime register.
REQ-026 SHALL make no atomic 64-bit access; lo/hi reads of mtime may tear (software re-reads hi).

Reset
REQ-027 SHALL on rst=0 at a clock edge set: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, clint_mtip=0, clint_ready=0, clint_rdata=0.
REQ-028 SHALL drop any in-flight request on reset; no clint_ready issued for it.
REQ-029 SHALL ignore clint_valid while rst=0.

Configuration
REQ-030 SHALL use macro CLINT_PRESCALER_EN: defined -> mtime ticks every RTC_DIV cycles per REQ-021.
REQ-031 SHALL without CLINT_PRESCALER_EN omit the prescaler and increment mtime every clk cycle; RTC_DIV unused.

Verification
REQ-032 SHALL cover: reset release, no writes -> mtime=0, clint_mtip=0, clint_msip=0; prescaler on, RTC_DIV=4 -> mtime=1 after 4 cycles, 2 after 8.
REQ-033 SHALL cover: write 0x4004=0, 0x4000=10 with mtime<10 -> clint_mtip rises the cycle after mtime reaches 10; write 0x4004=0xFFFFFFFF -> clint_mtip falls two cycles after that write's acceptance.
REQ-034 SHALL cover: write 0x0000=0xFFFFFFFF -> clint_msip=1, read 0x0000 returns 0x00000001; write 0 -> clint_msip=0.
REQ-035 SHALL cover: write 0xBFF8=0xFFFFFFFF, 0xBFFC=0xFFFFFFFF -> mtime wraps to 0 on next tick.
REQ-036 SHALL cover: write 0xBFF8 wstrb=0b0010 data 0x0000AB00 coincident with tick -> byte1=0xAB, other bytes incremented.
REQ-037 SHALL cover: read 0x1234 -> clint_rdata=0, clint_ready one cycle later; back-to-back valid on the ready cycle -> second ready next cycle; rst=0 with request in flight -> no ready.
